// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode map and the memory-stage FSM encoding.
package cpu_defs;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SW  = 6'b010000;
  localparam logic [5:0] OP_LW  = 6'b010001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100001;

  typedef enum logic {RUN = 1'b0, MEM = 1'b1} state_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: is_alu_op = 1'b1;
      default:                                       is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for an outstanding data-memory access.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)                     cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT))   cnt <= cnt + CW'(1);
  end

  // Fires in the last permitted wait cycle, so req is high exactly TIMEOUT cycles.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory/commit stage: ALU writeback, branch redirect, and LW/SW over a req/ack port.
module mem_stage
  import cpu_defs::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [5:0]    ex_op,
  input  logic [DW-1:0] ex_alu_o,
  input  logic [AW-1:0] ex_addr_o,
  input  logic          ex_ife,
  input  logic [RW-1:0] ex_rd,
  output logic          stall_o,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          br_taken,
  output logic [AW-1:0] br_target,
  output logic          err
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
  } mreq_t;

  state_t state, state_nx;
  mreq_t  mreq;
  logic   req_q;
  logic   is_mem, issue, misalign, take_br, wb_alu, acked, expired;

  always_comb begin
    is_mem   = (ex_op == OP_SW) || (ex_op == OP_LW);
    issue    = 1'b0;
    misalign = 1'b0;
    take_br  = 1'b0;
    wb_alu   = 1'b0;
    if (state == RUN && ex_valid) begin
      issue    = is_mem && (ex_addr_o[1:0] == 2'b00);
      misalign = is_mem && (ex_addr_o[1:0] != 2'b00);
      take_br  = (ex_op == OP_JMP) || ((ex_op == OP_BEQ) && ex_ife);
      wb_alu   = is_alu_op(ex_op) && (ex_rd != '0);
    end
  end

  assign acked = (state == MEM) && req_q && dmem_ack;

  always_comb begin
    state_nx = state;
    case (state)
      RUN: if (issue)            state_nx = MEM;
      MEM: if (acked || expired) state_nx = RUN;
      default:                   state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == RUN),
    .en      (state == MEM),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      mreq      <= '0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      err       <= 1'b0;
    end else begin
      wb_we    <= 1'b0;
      br_taken <= 1'b0;
      if (take_br) begin
        br_taken  <= 1'b1;
        br_target <= ex_addr_o;
      end
      if (wb_alu) begin
        wb_we   <= 1'b1;
        wb_rd   <= ex_rd;
        wb_data <= ex_alu_o;
      end
      if (misalign) err <= 1'b1;
      if (issue) begin
        req_q <= 1'b1;
        mreq  <= '{we: (ex_op == OP_SW), addr: {ex_addr_o[AW-1:2], 2'b00},
                   wdata: ex_alu_o, rd: ex_rd};
      end
      // Ack beats a same-cycle timeout; an aborted load never writes back.
      if (acked) begin
        req_q <= 1'b0;
        if (!mreq.we && mreq.rd != '0) begin
          wb_we   <= 1'b1;
          wb_rd   <= mreq.rd;
          wb_data <= dmem_rdata;
        end
      end else if (expired) begin
        req_q <= 1'b0;
        err   <= 1'b1;
      end
    end
  end

  assign stall_o    = (state == MEM) || issue;
  assign dmem_req   = req_q && !rst;
  assign dmem_we    = mreq.we;
  assign dmem_addr  = mreq.addr;
  assign dmem_wdata = mreq.wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected events, a forked monitor pops and compares.
module tb_mem_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ife, dmem_ack;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu_o, ex_addr_o, dmem_rdata;
  logic [4:0]  ex_rd;
  logic        stall_o, dmem_req, dmem_we, wb_we, br_taken, err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data, br_target;
  logic [4:0]  wb_rd;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;

  wb_t         exp_wb[$];
  logic [31:0] exp_br[$];
  req_t        exp_req[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_o(ex_alu_o),
    .ex_addr_o(ex_addr_o), .ex_ife(ex_ife), .ex_rd(ex_rd), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target), .err(err)
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One-cycle instruction presentation; st is stall_o seen while it is presented.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] addr,
                       input logic ife, input logic [4:0] rd, output logic st);
    ex_valid = 1'b1; ex_op = op; ex_alu_o = alu; ex_addr_o = addr; ex_ife = ife; ex_rd = rd;
    #1 st = stall_o;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic monitor();
    logic prev_req = 1'b0;
    wb_t  w;
    req_t r;
    logic [31:0] b;
    forever begin
      @(negedge clk);
      if (wb_we) begin
        if (exp_wb.size() == 0) check("wb_unexpected", 64'(wb_we), 64'd0);
        else begin
          w = exp_wb.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(w.rd));
          check("wb_data", 64'(wb_data), 64'(w.data));
        end
      end
      if (br_taken) begin
        if (exp_br.size() == 0) check("br_unexpected", 64'(br_taken), 64'd0);
        else begin
          b = exp_br.pop_front();
          check("br_target", 64'(br_target), 64'(b));
        end
      end
      if (dmem_req && !prev_req) begin
        if (exp_req.size() == 0) check("req_unexpected", 64'(dmem_req), 64'd0);
        else begin
          r = exp_req.pop_front();
          check("req_we", 64'(dmem_we), 64'(r.we));
          check("req_addr", 64'(dmem_addr), 64'(r.addr));
          check("req_wdata", 64'(dmem_wdata), 64'(r.wdata));
        end
      end
      prev_req = dmem_req;
    end
  endtask

  initial begin
    logic st;
    int   cyc;
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_alu_o = '0; ex_addr_o = '0; ex_ife = 1'b0;
    ex_rd = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    fork monitor(); join_none
    tick(); tick();
    check("rst_wb_we", 64'(wb_we), 0);
    check("rst_br", 64'(br_taken), 0);
    check("rst_req", 64'(dmem_req), 0);
    check("rst_err", 64'(err), 0);
    check("rst_stall", 64'(stall_o), 0);
    check("rst_addr", 64'(dmem_addr), 0);
    rst = 1'b0;
    tick();

    // ALU commit, then rd=0 suppression
    exp_wb.push_back('{rd: 5'd3, data: 32'h15});
    issue(OP_ADD, 32'h15, 32'h0, 1'b0, 5'd3, st);
    check("alu_stall", 64'(st), 0);
    issue(OP_XOR, 32'h99, 32'h0, 1'b0, 5'd0, st);
    tick();

    // SW 0x100, ack on second MEM cycle
    exp_req.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF});
    issue(OP_SW, 32'hDEADBEEF, 32'h100, 1'b0, 5'd6, st);
    check("sw_stall_issue", 64'(st), 1);
    check("sw_stall_mem", 64'(stall_o), 1);
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("sw_req_drop", 64'(dmem_req), 0);
    check("sw_stall_done", 64'(stall_o), 0);

    // LW 0x100, ack after 2 cycles
    exp_req.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_wb.push_back('{rd: 5'd7, data: 32'hDEADBEEF});
    issue(OP_LW, 32'h0, 32'h100, 1'b0, 5'd7, st);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("lw_wb_we", 64'(wb_we), 1);
    tick();

    // Minimum-occupancy loads: rd=2 commits, rd=0 suppressed
    exp_req.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_wb.push_back('{rd: 5'd2, data: 32'hCAFE0001});
    issue(OP_LW, 32'h0, 32'h104, 1'b0, 5'd2, st);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
    tick();
    dmem_ack = 1'b0;
    check("lw_min_req_drop", 64'(dmem_req), 0);
    exp_req.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0});
    issue(OP_LW, 32'h0, 32'h108, 1'b0, 5'd0, st);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
    tick();
    dmem_ack = 1'b0;
    tick();

    // Branches
    exp_br.push_back(32'h40);
    issue(OP_BEQ, 32'h0, 32'h40, 1'b1, 5'd0, st);
    issue(OP_BEQ, 32'h0, 32'h60, 1'b0, 5'd0, st);
    exp_br.push_back(32'h80);
    issue(OP_JMP, 32'h0, 32'h80, 1'b0, 5'd0, st);
    tick();
    check("err_before_timeout", 64'(err), 0);

    // Timeout; an ALU op held during MEM commits once back in RUN
    exp_req.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    issue(OP_LW, 32'h0, 32'h200, 1'b0, 5'd9, st);
    cyc = 0;
    while (dmem_req && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        ex_valid = 1'b1; ex_op = OP_SUB; ex_alu_o = 32'h77; ex_rd = 5'd4;
        exp_wb.push_back('{rd: 5'd4, data: 32'h77});
      end
      tick();
    end
    check("timeout_req_cycles", 64'(cyc), 15);
    check("timeout_err", 64'(err), 1);
    check("timeout_stall", 64'(stall_o), 0);
    tick();
    ex_valid = 1'b0;
    tick();

    // Reset clears err; misaligned load sets it with no access
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_err_clear", 64'(err), 0);
    issue(OP_LW, 32'h0, 32'h102, 1'b0, 5'd5, st);
    check("misalign_stall", 64'(st), 0);
    check("misalign_err", 64'(err), 1);
    check("misalign_req", 64'(dmem_req), 0);
    tick();

    // Reset mid-SW, then a late ack must be ignored
    exp_req.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h12345678});
    issue(OP_SW, 32'h12345678, 32'h300, 1'b0, 5'd1, st);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_req", 64'(dmem_req), 0);
    check("rst_mid_err", 64'(err), 0);
    check("rst_mid_stall", 64'(stall_o), 0);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    tick();
    dmem_ack = 1'b0;
    tick();
    check("late_ack_req", 64'(dmem_req), 0);
    check("late_ack_wb", 64'(wb_we), 0);
    tick(); tick();

    check("wb_queue_drained", 64'(exp_wb.size()), 0);
    check("br_queue_drained", 64'(exp_br.size()), 0);
    check("req_queue_drained", 64'(exp_req.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
